nv_nvdla_mcif_csb_logic: RTL
============================

Name: nv_nvdla_mcif_csb_logic

Overview:
- Initiator side of the MCIF register-file interface: converts CSB request packets into single-cycle register accesses (reg_offset / reg_wr_en / reg_wr_data) and packs reg_rd_data into CSB responses.
- Sits between the CSB master routing tree and the MCIF CSB register file.
- Fixed two-stage pipeline; accepts one request per cycle.
- Detects out-of-range offsets and partial-byte-enable writes, and reports them as errors.

Parameters:
- MAX_OFFSET, 12'h01c, highest valid byte offset; accesses above it are errors.
- REQ_PD_W, 63, request packet width.
- RESP_PD_W, 34, response packet width.

Ports:
- nvdla_core_clk  input  1  clock
- nvdla_core_rstn  input  1  reset, asynchronous, active-low
- csb2mcif_req_pvld  input  1  request valid
- csb2mcif_req_prdy  output  1  request ready
- csb2mcif_req_pd  input  63  request packet: [21:0] word addr, [53:22] wdat, [54] write, [55] nposted, [56] srcpriv (ignored), [60:57] wrbe, [62:61] level (ignored)
- mcif2csb_resp_valid  output  1  response valid; one-cycle pulse, no backpressure
- mcif2csb_resp_pd  output  34  response: [31:0] rdata, [32] error, [33] type (0 = read data, 1 = write ack)
- reg_offset  output  12  byte offset to the register file
- reg_wr_data  output  32  write data
- reg_wr_en  output  1  write strobe
- reg_rd_data  input  32  combinational read data from the register file

Behaviour:
- Reset is nvdla_core_rstn, asynchronous, active-low; clock is nvdla_core_clk. All flops reset asynchronously.
- Reset values:
  - req_prdy flop = 0; it goes to 1 on the first clock edge after reset release and stays 1.
  - resp_valid = 0, resp_pd = 0.
  - reg_offset = 0, reg_wr_data = 0, reg_wr_en = 0.
  - Internal stage-1 valid = 0.
- Accept: a request is accepted in cycle T when pvld & prdy. No stall source exists; back-to-back acceptance happens every cycle.
- Stage 1 (registered at the edge ending T), active in cycle T+1:
  - reg_offset = {addr[9:0], 2'b00}; addr[21:10] is ignored, because routing is done upstream.
  - reg_wr_data = wdat.
  - range_err = (offset > MAX_OFFSET).
  - be_err = write & (wrbe != 4'hf).
  - reg_wr_en = s1_vld & write & !range_err & !be_err. It is high for exactly cycle T+1, and the register file commits on the edge ending T+1.
  - Reads: reg_rd_data is sampled during T+1 and captured into the response flop at the edge ending T+1.
- Stage 2, cycle T+2: resp_valid = 1 for exactly one cycle when the stage-1 request is one of:
  - a read: type = 0; rdata = range_err ? 0 : reg_rd_data; error = range_err.
  - a non-posted write: type = 1; rdata = 0; error = range_err | be_err.
- Posted writes (nposted = 0) produce no response, including when in error. An erroneous posted write is silently dropped: reg_wr_en stays 0.
- While reg_wr_en = 0, reg_offset and reg_wr_data hold their last values. Their values are don't-care for the register file, but the hold is required for power.
- Ordering: responses leave in acceptance order, with fixed latency 2. Consecutive requests produce consecutive response pulses with no bubble.
- Write followed immediately by a read to the same offset: the read in T+2 returns the new value, because the write committed at the edge ending T+1.
- When pvld = 0, stage 1 is invalid and no strobes or responses are produced in the following cycles.
- Reset asserted mid-operation:
  - Any in-flight stage-1 or stage-2 transaction is discarded; no response is emitted and reg_wr_en drops immediately.
  - prdy = 0 until one edge after reset release.
- srcpriv and level are accepted and ignored.

Test Plan:
- Reset release, pvld held high -> prdy = 0 during reset and the first post-reset cycle; the first accept happens in the second cycle; no response or strobe before that.
- Read addr 22'h005 (offset 0x014) with reg_rd_data = 32'h0000ffff at T+1 -> at T+2 resp_valid = 1, resp_pd = {1'b0, 1'b0, 32'h0000ffff}; reg_wr_en never high.
- Non-posted write addr 22'h000, wdat = 32'h04030201, wrbe = f -> reg_wr_en = 1 at T+1 with offset 0x000 and data 32'h04030201; at T+2 resp_pd = {1'b1, 1'b0, 32'h0}. The same write with nposted = 0 -> strobe only, no response.
- Read addr 22'h010 (offset 0x040 > 0x01c) -> resp_pd = {0, 1, 32'h0}. Non-posted write with wrbe = 4'h3 -> no strobe; resp_pd = {1, 1, 32'h0}.
- Back-to-back stream over 4 cycles (write 0x008, read 0x008, posted write 0x00c, read 0x00c) -> strobes in cycles 1 and 3; responses in cycles 3 and 5 carry the newly written data; no response for the posted write; no bubbles.
- Assert rstn low in the cycle after a non-posted write is accepted -> reg_wr_en falls immediately; no response is ever emitted; normal operation resumes after reset release.

Source files
------------

// File: rtl/nv_nvdla_mcif_csb_logic_if.sv
// nv_nvdla_mcif_csb_logic_if: CSB request/response channel between the routing tree and the MCIF CSB logic
interface nv_nvdla_mcif_csb_logic_if #(
  parameter int REQ_PD_W  = 63,
  parameter int RESP_PD_W = 34
);
  logic                 csb2mcif_req_pvld;
  logic                 csb2mcif_req_prdy;
  logic [REQ_PD_W-1:0]  csb2mcif_req_pd;
  logic                 mcif2csb_resp_valid;
  logic [RESP_PD_W-1:0] mcif2csb_resp_pd;
  modport master (
    output csb2mcif_req_pvld, csb2mcif_req_pd,
    input  csb2mcif_req_prdy, mcif2csb_resp_valid, mcif2csb_resp_pd
  );
  modport slave (
    input  csb2mcif_req_pvld, csb2mcif_req_pd,
    output csb2mcif_req_prdy, mcif2csb_resp_valid, mcif2csb_resp_pd
  );
endinterface

// File: rtl/nv_nvdla_mcif_csb_logic.sv
// nv_nvdla_mcif_csb_logic: turns CSB requests into single-cycle register accesses and packs CSB responses
module nv_nvdla_mcif_csb_logic #(
  parameter logic [11:0] MAX_OFFSET = 12'h01c,
  parameter int          REQ_PD_W   = 63,
  parameter int          RESP_PD_W  = 34
) (
  input  logic                      nvdla_core_clk,
  input  logic                      nvdla_core_rstn,
  nv_nvdla_mcif_csb_logic_if.slave  csb,
  output logic [11:0]               reg_offset,
  output logic [31:0]               reg_wr_data,
  output logic                      reg_wr_en,
  input  logic [31:0]               reg_rd_data
);
  logic [REQ_PD_W-1:0]  pd;
  logic [RESP_PD_W-1:0] resp_pd;
  logic [11:0]          offset;
  logic                 accept, wr, np, range_err, be_err, resp_fire, unused_bits;
  logic                 req_prdy, resp_valid;
  logic                 s1_vld, s1_wr, s1_np, s1_range_err, s1_be_err;
  assign pd          = csb.csb2mcif_req_pd;
  assign accept      = csb.csb2mcif_req_pvld & req_prdy;
  assign offset      = {pd[9:0], 2'b00};
  assign wr          = pd[54];
  assign np          = pd[55];
  assign range_err   = offset > MAX_OFFSET;
  assign be_err      = wr & (pd[60:57] != 4'hf);
  // Upper address bits are routed upstream; srcpriv and level carry no meaning here.
  assign unused_bits = ^{pd[62:61], pd[56], pd[21:10]};
  assign reg_wr_en   = s1_vld & s1_wr & ~s1_range_err & ~s1_be_err;
  assign resp_fire   = s1_vld & (~s1_wr | s1_np);
  assign csb.csb2mcif_req_prdy   = req_prdy;
  assign csb.mcif2csb_resp_valid = resp_valid;
  assign csb.mcif2csb_resp_pd    = resp_pd;
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      req_prdy     <= 1'b0;
      s1_vld       <= 1'b0;
      s1_wr        <= 1'b0;
      s1_np        <= 1'b0;
      s1_range_err <= 1'b0;
      s1_be_err    <= 1'b0;
    end else begin
      req_prdy <= 1'b1;
      s1_vld   <= accept;
      if (accept) begin
        s1_wr        <= wr;
        s1_np        <= np;
        s1_range_err <= range_err;
        s1_be_err    <= be_err;
      end
    end
  end
  // Offset and write data only move when a request lands, so idle cycles keep the bus quiet.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      reg_offset  <= 12'h000;
      reg_wr_data <= 32'h0;
    end else if (accept) begin
      reg_offset  <= offset;
      if (wr) reg_wr_data <= pd[53:22];
    end
  end
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      resp_valid <= 1'b0;
      resp_pd    <= '0;
    end else begin
      resp_valid <= resp_fire;
      if (resp_fire)
        resp_pd <= s1_wr ? {1'b1, s1_range_err | s1_be_err, 32'h0}
                         : {1'b0, s1_range_err, s1_range_err ? 32'h0 : reg_rd_data};
    end
  end
endmodule
